seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider_if.sv | 25 ++
 rtl/seq_restoring_divider.sv | 130 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// Request/response bundle for the sequential restoring divider.
// The datapath drives start and operands (master); the divider drives
// the handshake status and the registered results (slave).
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB
// first. A request is taken on start while idle. done pulses for one cycle
// once the registered quotient/remainder are valid. Divide-by-zero skips
// the iteration and reports all-ones quotient with the dividend as remainder.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;       // partial remainder, one guard bit
  logic [WIDTH-1:0] q_q, q_d;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // Trial subtraction of the shifted partial remainder. One extra bit above
  // the W+1-bit shifted value carries the borrow, i.e. the sign of T.
  logic [WIDTH+1:0] trial;
  assign trial = {r_q, q_q[WIDTH-1]} - (WIDTH+2)'(dvs_q);

  // Next-state and datapath update for the IDLE/RUN/FIN sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dvs_d  = bus.divisor;
          q_d    = bus.dividend;
          r_d    = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (bus.divisor == '0) begin
            dz_d    = 1'b1;
            state_d = ST_FIN;
          end else begin
            dz_d    = 1'b0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Negative trial result means restore: keep the shifted remainder.
        if (trial[WIDTH+1]) begin
          r_d = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          r_d = trial[WIDTH:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = ST_FIN;
      end
      ST_FIN: begin
        if (dz_q) begin
          quo_d = '1;
          rem_d = q_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = q_q;
          rem_d = r_q[WIDTH-1:0];
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset wins over any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep bench for seq_restoring_divider at WIDTH=4 and WIDTH=8.
module tb_seq_restoring_divider;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  seq_restoring_divider_if #(.WIDTH(4)) b4 ();
  seq_restoring_divider_if #(.WIDTH(8)) b8 ();

  seq_restoring_divider #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  seq_restoring_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
  endtask

  // Issue one WIDTH=4 op from an idle (or done) cycle and wait for done.
  // lat = edges after the accepting edge until done is seen;
  // bcnt = sampled cycles with busy high; held = results unchanged while running.
  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     output logic [3:0] q, output logic [3:0] r, output logic dz,
                     output int lat, output int bcnt, output bit held);
    logic [3:0] q0;
    logic [3:0] r0;
    q0 = b4.quotient; r0 = b4.remainder;
    held = 1'b1; lat = 0; bcnt = 0;
    b4.start = 1'b1; b4.dividend = a; b4.divisor = b;
    @(posedge clk); #1;
    b4.start = 1'b0;
    b4.dividend = 4'($urandom); b4.divisor = 4'($urandom);
    while (!b4.done && lat < 40) begin
      if (b4.busy) bcnt++;
      if (b4.quotient !== q0 || b4.remainder !== r0) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) chk("op4_timeout", 32'(lat), 32'd0);
    q = b4.quotient; r = b4.remainder; dz = b4.div_by_zero;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] q, output logic [7:0] r, output logic dz,
                     output int lat);
    lat = 0;
    b8.start = 1'b1; b8.dividend = a; b8.divisor = b;
    @(posedge clk); #1;
    b8.start = 1'b0;
    b8.dividend = 8'($urandom); b8.divisor = 8'($urandom);
    while (!b8.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 60) chk("op8_timeout", 32'(lat), 32'd0);
    q = b8.quotient; r = b8.remainder; dz = b8.div_by_zero;
  endtask

  // Reconstruct the dividend the way the 4-bit multiplier would.
  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (y[i]) p = p + (8'(x) << i);
    return p;
  endfunction

  logic [3:0] q, r;
  logic [7:0] q8, r8, a8, d8;
  logic       dz;
  int         lat, bcnt, gap, seen;
  bit         held;

  typedef struct { logic [3:0] a; logic [3:0] b; logic [3:0] q; logic [3:0] r; } vec_t;
  vec_t edges [4];

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    b4.start = 1'b0; b4.dividend = '0; b4.divisor = '0;
    b8.start = 1'b0; b8.dividend = '0; b8.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(b4.busy), 32'd0);
    chk("rst_done", 32'(b4.done), 32'd0);
    chk("rst_quo",  32'(b4.quotient), 32'd0);
    chk("rst_rem",  32'(b4.remainder), 32'd0);
    chk("rst_dbz",  32'(b4.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 13/3: done lands WIDTH+1 edges after acceptance; busy every cycle before it.
    op4(4'd13, 4'd3, q, r, dz, lat, bcnt, held);
    chk("b13_lat", 32'(lat), 32'd5);
    chk("b13_busy", 32'(bcnt), 32'd5);
    chk("b13_held", 32'(held), 32'd1);
    chk("b13_q", 32'(q), 32'd4);
    chk("b13_r", 32'(r), 32'd1);
    chk("b13_dz", 32'(dz), 32'd0);
    chk("b13_busy_at_done", 32'(b4.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("b13_done_pulse", 32'(b4.done), 32'd0);
    chk("b13_hold_q", 32'(b4.quotient), 32'd4);
    chk("b13_hold_r", 32'(b4.remainder), 32'd1);

    edges[0] = '{4'd15, 4'd1, 4'd15, 4'd0};
    edges[1] = '{4'd0, 4'd5, 4'd0, 4'd0};
    edges[2] = '{4'd2, 4'd9, 4'd0, 4'd2};
    edges[3] = '{4'd15, 4'd15, 4'd1, 4'd0};
    foreach (edges[i]) begin
      op4(edges[i].a, edges[i].b, q, r, dz, lat, bcnt, held);
      chk("edge_q", 32'(q), 32'(edges[i].q));
      chk("edge_r", 32'(r), 32'(edges[i].r));
    end

    // Divide by zero, then a normal op clears the flag.
    op4(4'd7, 4'd0, q, r, dz, lat, bcnt, held);
    chk("dz_lat", 32'(lat), 32'd1);
    chk("dz_flag", 32'(dz), 32'd1);
    chk("dz_q", 32'(q), 32'd15);
    chk("dz_r", 32'(r), 32'd7);
    op4(4'd9, 4'd2, q, r, dz, lat, bcnt, held);
    chk("after_dz_q", 32'(q), 32'd4);
    chk("after_dz_r", 32'(r), 32'd1);
    chk("after_dz_flag", 32'(dz), 32'd0);
    chk("after_dz_lat", 32'(lat), 32'd5);

    // start held through the run with operands changing: only 13/3 is done.
    // start still high in the done cycle starts 5/1, whose done is WIDTH+2 later.
    b4.start = 1'b1; b4.dividend = 4'd13; b4.divisor = 4'd3;
    @(posedge clk); #1;
    b4.dividend = 4'd5; b4.divisor = 4'd1;
    lat = 0;
    while (!b4.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_lat", 32'(lat), 32'd5);
    chk("hold_q", 32'(b4.quotient), 32'd4);
    chk("hold_r", 32'(b4.remainder), 32'd1);
    @(posedge clk); #1;
    b4.start = 1'b0;
    gap = 1;
    while (!b4.done && gap < 40) begin
      @(posedge clk); #1;
      gap++;
    end
    chk("b2b_gap", 32'(gap), 32'd6);
    chk("b2b_q", 32'(b4.quotient), 32'd5);
    chk("b2b_r", 32'(b4.remainder), 32'd0);
    @(posedge clk); #1;

    // Reset during RUN aborts with no done afterwards.
    b4.start = 1'b1; b4.dividend = 4'd13; b4.divisor = 4'd3;
    @(posedge clk); #1;
    b4.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(b4.busy), 32'd0);
    chk("mid_rst_quo", 32'(b4.quotient), 32'd0);
    chk("mid_rst_rem", 32'(b4.remainder), 32'd0);
    chk("mid_rst_dbz", 32'(b4.div_by_zero), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (b4.done || b4.busy) seen++;
      @(posedge clk); #1;
    end
    chk("mid_rst_nodone", 32'(seen), 32'd0);
    op4(4'd11, 4'd4, q, r, dz, lat, bcnt, held);
    chk("post_rst_q", 32'(q), 32'd2);
    chk("post_rst_r", 32'(r), 32'd3);

    // Exhaustive WIDTH=4 sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op4(4'(a), 4'(b), q, r, dz, lat, bcnt, held);
        if (b == 0) begin
          chk("sw_dz_q", 32'(q), 32'd15);
          chk("sw_dz_r", 32'(r), 32'(a));
          chk("sw_dz_f", 32'(dz), 32'd1);
        end else begin
          chk("sw_q", 32'(q), 32'(a / b));
          chk("sw_r", 32'(r), 32'(a % b));
          chk("sw_mul", 32'(mul4(q, 4'(b)) + 8'(r)), 32'(a));
          chk("sw_rltd", 32'(r < 4'(b)), 32'd1);
          chk("sw_f", 32'(dz), 32'd0);
        end
      end
    end

    // Random WIDTH=8 sweep, with the boundary divisors forced in.
    for (int i = 0; i < 150; i++) begin
      a8 = 8'($urandom);
      d8 = (i == 0) ? 8'd0 : (i == 1) ? 8'd1 : (i == 2) ? 8'd255 : 8'($urandom);
      op8(a8, d8, q8, r8, dz, lat);
      if (d8 == 8'd0) begin
        chk("w8_dz_q", 32'(q8), 32'd255);
        chk("w8_dz_r", 32'(r8), 32'(a8));
        chk("w8_dz_lat", 32'(lat), 32'd1);
      end else begin
        chk("w8_q", 32'(q8), 32'(a8 / d8));
        chk("w8_r", 32'(r8), 32'(a8 % d8));
        chk("w8_lat", 32'(lat), 32'd9);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
